// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 matrix keypad scanner.
package keypad_pkg;

  localparam int NROWS = 4;
  localparam int NCOLS = 4;
  localparam int NKEYS = NROWS * NCOLS;

  typedef enum logic [1:0] {
    IDLE,
    PRESSED,
    LOCK
  } state_e;

  function automatic logic [3:0] onehot_idx(input logic [NKEYS-1:0] v);
    logic [3:0] idx;
    idx = '0;
    for (int i = 0; i < NKEYS; i++) begin
      if (v[i]) idx = 4'(i);
    end
    return idx;
  endfunction

  // Clearing the lowest set bit leaves something only when two or more keys are closed.
  function automatic logic multi_hot(input logic [NKEYS-1:0] v);
    return (v & (v - NKEYS'(1))) != '0;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous level inputs, with a configurable reset value.
module sync_2ff #(
  parameter int           W       = 4,
  parameter logic [W-1:0] RST_VAL = '1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/keypad_scan.sv
// 4x4 hex keypad scanner: row drive, column sampling, frame debounce and
// single-key event generation feeding a 16-bit nibble entry register.
module keypad_scan
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV        = 1000,
  parameter int DEBOUNCE_FRAMES = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic [3:0]  row_n,
  input  logic [3:0]  col_n,
  output logic        key_valid,
  output logic [3:0]  key_code,
  output logic        key_down,
  output logic [15:0] hex_value
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CNT_W = $clog2(DEBOUNCE_FRAMES + 1);

  logic [NCOLS-1:0] col_s;
  logic [DIV_W-1:0] div_q, div_d;
  logic [1:0]       row_q, row_d;
  logic [3:0]       row_n_q, row_n_d;
  logic [NKEYS-1:0] snap_q, snap_d;
  logic [NKEYS-1:0] prev_q, prev_d;
  logic [NKEYS-1:0] comm_q, comm_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             commit_q, commit_d;
  state_e           state_q, state_d;
  logic             kv_q, kv_d;
  logic [3:0]       code_q, code_d;
  logic             down_q, down_d;
  logic [15:0]      hex_q, hex_d;
  logic             sample;
  logic             frame_end;

  sync_2ff #(.W(NCOLS), .RST_VAL('1)) u_col_sync (
    .clk (clk),
    .rst (rst),
    .d_i (col_n),
    .q_o (col_s)
  );

  // Scan and debounce: the frame is complete in snap_d on the cycle row 3 is sampled.
  always_comb begin
    sample    = (div_q == DIV_W'(SCAN_DIV - 1));
    frame_end = sample && (row_q == 2'd3);
    div_d     = sample ? '0 : div_q + DIV_W'(1);
    row_d     = row_q;
    row_n_d   = row_n_q;
    snap_d    = snap_q;
    prev_d    = prev_q;
    cnt_d     = cnt_q;
    comm_d    = comm_q;
    commit_d  = 1'b0;
    if (sample) begin
      snap_d[{row_q, 2'b00} +: NCOLS] = ~col_s;
      row_d   = row_q + 2'd1;
      row_n_d = {row_n_q[2:0], row_n_q[3]};
    end
    if (frame_end) begin
      if (snap_d == prev_q) begin
        if (cnt_q != CNT_W'(DEBOUNCE_FRAMES)) cnt_d = cnt_q + CNT_W'(1);
      end else begin
        cnt_d  = CNT_W'(1);
        prev_d = snap_d;
      end
      if ((cnt_d == CNT_W'(DEBOUNCE_FRAMES)) && (snap_d != comm_q)) begin
        comm_d   = snap_d;
        commit_d = 1'b1;
      end
    end
  end

  // Event FSM: reacts only in the cycle after the committed state changes.
  always_comb begin
    state_d = state_q;
    kv_d    = 1'b0;
    code_d  = code_q;
    hex_d   = hex_q;
    down_d  = (comm_q != '0);
    if (commit_q) begin
      case (state_q)
        IDLE: begin
          if (comm_q != '0) begin
            if (multi_hot(comm_q)) begin
              state_d = LOCK;
            end else begin
              state_d = PRESSED;
              kv_d    = 1'b1;
              code_d  = onehot_idx(comm_q);
              hex_d   = {hex_q[11:0], onehot_idx(comm_q)};
            end
          end
        end
        PRESSED: state_d = (comm_q == '0) ? IDLE : LOCK;
        LOCK:    if (comm_q == '0) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q    <= '0;
      row_q    <= '0;
      row_n_q  <= 4'b1110;
      snap_q   <= '0;
      prev_q   <= '0;
      cnt_q    <= '0;
      comm_q   <= '0;
      commit_q <= 1'b0;
      state_q  <= IDLE;
      kv_q     <= 1'b0;
      code_q   <= '0;
      down_q   <= 1'b0;
      hex_q    <= '0;
    end else begin
      div_q    <= div_d;
      row_q    <= row_d;
      row_n_q  <= row_n_d;
      snap_q   <= snap_d;
      prev_q   <= prev_d;
      cnt_q    <= cnt_d;
      comm_q   <= comm_d;
      commit_q <= commit_d;
      state_q  <= state_d;
      kv_q     <= kv_d;
      code_q   <= code_d;
      down_q   <= down_d;
      hex_q    <= hex_d;
    end
  end

  assign row_n     = row_n_q;
  assign key_valid = kv_q;
  assign key_code  = code_q;
  assign key_down  = down_q;
  assign hex_value = hex_q;

endmodule

// File: tb/tb_keypad_scan.sv
// Scoreboard bench for keypad_scan: a keypad model drives col_n from the
// pressed-key vector; expected events are queued and checked by a monitor.
module tb_keypad_scan;

  localparam int SD    = 4;
  localparam int DF    = 2;
  localparam int FRAME = 4 * SD;
  localparam int LAT   = 3 * FRAME + 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  row_n;
  logic [3:0]  col_n;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        key_down;
  logic [15:0] hex_value;

  logic [15:0] keys    = '0;
  logic [15:0] exp_hex = '0;
  logic [19:0] sb[$];
  int          total   = 0;
  int          bad     = 0;
  int          ev_cnt  = 0;

  keypad_scan #(.SCAN_DIV(SD), .DEBOUNCE_FRAMES(DF)) dut (
    .clk       (clk),
    .rst       (rst),
    .row_n     (row_n),
    .col_n     (col_n),
    .key_valid (key_valid),
    .key_code  (key_code),
    .key_down  (key_down),
    .hex_value (hex_value)
  );

  always #5 clk = ~clk;

  // Matrix model: a closed key pulls its column low while its row is driven.
  always_comb begin
    col_n = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!row_n[r] && keys[r*4+c]) col_n[c] = 1'b0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  // Monitor: every key_valid pulse must match the oldest queued expectation.
  initial begin
    logic [19:0] e;
    forever begin
      @(negedge clk);
      if (!rst && key_valid === 1'b1) begin
        ev_cnt++;
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_event: got code %0h hex %0h want none", key_code, hex_value);
        end else begin
          e = sb.pop_front();
          check("ev_code", 32'(key_code), 32'(e[19:16]));
          check("ev_hex", 32'(hex_value), 32'(e[15:0]));
        end
      end
    end
  end

  task automatic press_event(input int k);
    int start;
    bit seen;
    exp_hex = {exp_hex[11:0], 4'(k)};
    sb.push_back({4'(k), exp_hex});
    keys  = 16'(1) << k;
    start = ev_cnt;
    seen  = 1'b0;
    for (int i = 0; i < LAT && !seen; i++) begin
      @(negedge clk);
      #1;
      if (ev_cnt != start) seen = 1'b1;
    end
    check("event_latency", 32'(seen), 32'd1);
    check("key_down_on", 32'(key_down), 32'd1);
    repeat (FRAME) @(negedge clk);
  endtask

  task automatic release_keys();
    keys = '0;
    repeat (LAT) @(negedge clk);
    check("key_down_off", 32'(key_down), 32'd0);
  endtask

  initial begin
    logic [3:0] er;
    int seq[4];
    seq = '{1, 2, 3, 15};

    // 1. reset, mid-frame reset, row rotation
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (22) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_row_n", 32'(row_n), 32'hE);
    check("rst_valid", 32'(key_valid), 32'd0);
    check("rst_code", 32'(key_code), 32'd0);
    check("rst_down", 32'(key_down), 32'd0);
    check("rst_hex", 32'(hex_value), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      er = ~(4'b0001 << (i / 4));
      check("row_scan", 32'(row_n), 32'(er));
      @(negedge clk);
    end
    check("idle_valid", 32'(key_valid), 32'd0);
    check("idle_hex", 32'(hex_value), 32'd0);
    check("idle_down", 32'(key_down), 32'd0);

    // 2. single press row2/col1
    press_event(9);
    check("hex_single", 32'(hex_value), 32'h0009);
    release_keys();

    // 3. sequence
    for (int i = 0; i < 4; i++) begin
      press_event(seq[i]);
      release_keys();
    end
    check("hex_seq", 32'(hex_value), 32'h123F);
    press_event(0);
    release_keys();
    check("hex_seq5", 32'(hex_value), 32'h23F0);

    // 4. bounce on key 5
    for (int i = 0; i < 6; i++) begin
      keys = (i % 2 == 0) ? 16'h0020 : 16'h0000;
      repeat (FRAME) @(negedge clk);
    end
    keys = '0;
    repeat (LAT) @(negedge clk);
    check("bounce_down", 32'(key_down), 32'd0);
    check("bounce_hex", 32'(hex_value), 32'h23F0);

    // 5. multi-key lockout
    press_event(4);
    keys = 16'h0090;
    repeat (LAT) @(negedge clk);
    check("multi_down", 32'(key_down), 32'd1);
    keys = 16'h0080;
    repeat (LAT) @(negedge clk);
    check("lock_down", 32'(key_down), 32'd1);
    check("lock_hex", 32'(hex_value), 32'h3F04);
    release_keys();
    press_event(7);
    release_keys();
    check("hex_multi", 32'(hex_value), 32'hF047);

    // 6. key held through reset
    keys = 16'h0008;
    repeat (8) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst2_hex", 32'(hex_value), 32'd0);
    check("rst2_down", 32'(key_down), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    exp_hex = '0;
    press_event(3);
    check("hex_after_rst", 32'(hex_value), 32'h0003);
    release_keys();

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
